// File: rtl/cache_manager.sv
// Direct-mapped I/D cache front end with a shared block RAM port.
// D-cache is write-back/write-allocate; misses stall the pipeline while the FSM runs RAM transactions.
module cache_manager #(
  parameter int LINES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_read_in,
  input  logic         dc_read_in,
  input  logic         dc_write_in,
  input  logic [3:0]   dc_byte_w_en_in,
  input  logic [29:0]  ic_addr,
  input  logic [29:0]  dc_addr,
  input  logic [31:0]  data_from_reg,
  input  logic         ram_ready,
  input  logic [255:0] block_from_ram,
  output logic         mem_stall,
  output logic [31:0]  dc_data_out,
  output logic [31:0]  ic_data_out,
  output logic [2:0]   status,
  output logic [2:0]   counter,
  output logic         ram_en_out,
  output logic         ram_write_out,
  output logic [29:0]  ram_addr_out,
  output logic [255:0] dc_data_wb
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 27 - IDX_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DC_WB   = 3'd1;
  localparam logic [2:0] S_DC_FILL = 3'd2;
  localparam logic [2:0] S_IC_FILL = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [255:0]     ic_mem     [LINES];
  logic [TAG_W-1:0] ic_tag_mem [LINES];
  logic [255:0]     dc_mem     [LINES];
  logic [TAG_W-1:0] dc_tag_mem [LINES];

  logic [2:0]       state_q, state_d;
  logic [2:0]       counter_q, counter_d;
  logic [LINES-1:0] ic_valid_q, ic_valid_d;
  logic [LINES-1:0] dc_valid_q, dc_valid_d;
  logic [LINES-1:0] dc_dirty_q, dc_dirty_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_wr_q, ram_wr_d;
  logic [26:0]      blk_addr_q, blk_addr_d;
  logic [255:0]     wb_data_q, wb_data_d;

  logic [IDX_W-1:0] ic_idx, dc_idx, fill_idx;
  logic [2:0]       ic_off, dc_off;
  logic [TAG_W-1:0] ic_tag, dc_tag, fill_tag;
  logic [255:0]     ic_line, dc_line, store_line;
  logic [31:0]      ic_word, dc_word;
  logic             ic_hit, dc_hit, ic_miss, dc_miss, rdy, req_state;
  logic             ic_fill_we, dc_fill_we, dc_store_we;

  assign ic_idx   = ic_addr[IDX_W+2:3];
  assign ic_off   = ic_addr[2:0];
  assign ic_tag   = ic_addr[29:IDX_W+3];
  assign dc_idx   = dc_addr[IDX_W+2:3];
  assign dc_off   = dc_addr[2:0];
  assign dc_tag   = dc_addr[29:IDX_W+3];
  // Fills land at the captured request address, not the live pipeline address.
  assign fill_idx = blk_addr_q[IDX_W-1:0];
  assign fill_tag = blk_addr_q[26:IDX_W];

  assign ic_line = ic_mem[ic_idx];
  assign dc_line = dc_mem[dc_idx];
  assign ic_word = ic_line[32*int'(ic_off) +: 32];
  assign dc_word = dc_line[32*int'(dc_off) +: 32];

  assign ic_hit  = ic_valid_q[ic_idx] && (ic_tag_mem[ic_idx] == ic_tag);
  assign dc_hit  = dc_valid_q[dc_idx] && (dc_tag_mem[dc_idx] == dc_tag);
  assign ic_miss = ic_read_in && !ic_hit;
  assign dc_miss = (dc_read_in || dc_write_in) && !dc_hit;

  assign mem_stall   = (state_q != S_IDLE) || dc_miss || ic_miss;
  assign ic_data_out = ic_hit ? ic_word : 32'h0;
  assign dc_data_out = (dc_read_in && dc_hit) ? dc_word : 32'h0;

  assign rdy       = ram_en_q && ram_ready;
  assign req_state = (state_q == S_DC_WB) || (state_q == S_DC_FILL) || (state_q == S_IC_FILL);

  always_comb begin
    store_line = dc_line;
    for (int b = 0; b < 4; b++) begin
      if (dc_byte_w_en_in[b]) store_line[32*int'(dc_off) + 8*b +: 8] = data_from_reg[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ic_valid_d  = ic_valid_q;
    dc_valid_d  = dc_valid_q;
    dc_dirty_d  = dc_dirty_q;
    ic_fill_we  = 1'b0;
    dc_fill_we  = 1'b0;
    dc_store_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dc_miss) begin
          state_d = (dc_valid_q[dc_idx] && dc_dirty_q[dc_idx]) ? S_DC_WB : S_DC_FILL;
        end else if (ic_miss) begin
          state_d = S_IC_FILL;
        end
        if (dc_write_in && dc_hit && !mem_stall) begin
          dc_store_we        = 1'b1;
          dc_dirty_d[dc_idx] = 1'b1;
        end
      end
      S_DC_WB: if (rdy) state_d = S_DC_FILL;
      S_DC_FILL: begin
        if (rdy) begin
          dc_fill_we           = 1'b1;
          dc_valid_d[fill_idx] = 1'b1;
          dc_dirty_d[fill_idx] = 1'b0;
          state_d              = S_DONE;
        end
      end
      S_IC_FILL: begin
        if (rdy) begin
          ic_fill_we           = 1'b1;
          ic_valid_d[fill_idx] = 1'b1;
          state_d              = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM request fields are captured on the first cycle of a request state and held until ready.
  always_comb begin
    ram_en_d   = req_state && !rdy;
    ram_wr_d   = ram_wr_q;
    blk_addr_d = blk_addr_q;
    wb_data_d  = wb_data_q;
    if (req_state && !ram_en_q) begin
      case (state_q)
        S_DC_WB: begin
          ram_wr_d   = 1'b1;
          blk_addr_d = {dc_tag_mem[dc_idx], dc_idx};
          wb_data_d  = dc_line;
        end
        S_DC_FILL: begin
          ram_wr_d   = 1'b0;
          blk_addr_d = dc_addr[29:3];
        end
        default: begin
          ram_wr_d   = 1'b0;
          blk_addr_d = ic_addr[29:3];
        end
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q)  counter_d = 3'd0;
    else if (counter_q == 3'd7) counter_d = 3'd7;
    else                     counter_d = counter_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      counter_q  <= 3'd0;
      ic_valid_q <= '0;
      dc_valid_q <= '0;
      dc_dirty_q <= '0;
      ram_en_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      blk_addr_q <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      ic_valid_q <= ic_valid_d;
      dc_valid_q <= dc_valid_d;
      dc_dirty_q <= dc_dirty_d;
      ram_en_q   <= ram_en_d;
      ram_wr_q   <= ram_wr_d;
      blk_addr_q <= blk_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Arrays carry no reset; validity is tracked solely by the valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ic_fill_we) begin
        ic_mem[fill_idx]     <= block_from_ram;
        ic_tag_mem[fill_idx] <= fill_tag;
      end
      if (dc_fill_we) begin
        dc_mem[fill_idx]     <= block_from_ram;
        dc_tag_mem[fill_idx] <= fill_tag;
      end else if (dc_store_we) begin
        dc_mem[dc_idx] <= store_line;
      end
    end
  end

  assign status        = state_q;
  assign counter       = counter_q;
  assign ram_en_out    = ram_en_q;
  assign ram_write_out = ram_wr_q;
  assign ram_addr_out  = {blk_addr_q, 3'b000};
  assign dc_data_wb    = wb_data_q;
endmodule

// File: tb/tb_cache_manager.sv
// Scoreboard bench for cache_manager: expected RAM requests and read data are queued by the
// stimulus and popped by independent monitors when the DUT presents them.
module tb_cache_manager;
  logic         clk = 1'b0;
  logic         rst;
  logic         ic_read_in, dc_read_in, dc_write_in;
  logic [3:0]   dc_byte_w_en_in;
  logic [29:0]  ic_addr, dc_addr;
  logic [31:0]  data_from_reg;
  logic         ram_ready;
  logic [255:0] block_from_ram;
  logic         mem_stall;
  logic [31:0]  dc_data_out, ic_data_out;
  logic [2:0]   status, counter;
  logic         ram_en_out, ram_write_out;
  logic [29:0]  ram_addr_out;
  logic [255:0] dc_data_wb;

  cache_manager #(.LINES(64)) dut (
    .clk(clk), .rst(rst), .ic_read_in(ic_read_in), .dc_read_in(dc_read_in),
    .dc_write_in(dc_write_in), .dc_byte_w_en_in(dc_byte_w_en_in), .ic_addr(ic_addr),
    .dc_addr(dc_addr), .data_from_reg(data_from_reg), .ram_ready(ram_ready),
    .block_from_ram(block_from_ram), .mem_stall(mem_stall), .dc_data_out(dc_data_out),
    .ic_data_out(ic_data_out), .status(status), .counter(counter), .ram_en_out(ram_en_out),
    .ram_write_out(ram_write_out), .ram_addr_out(ram_addr_out), .dc_data_wb(dc_data_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wb5;
  } ram_exp_t;

  ram_exp_t    ram_q[$];
  logic [31:0] ic_q[$];
  logic [31:0] dc_q[$];

  int checks = 0;
  int errors = 0;
  int ram_lat = 2;
  logic [255:0] fill_block;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_block(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = base + step * i;
    return b;
  endfunction

  // RAM model: answers ram_lat cycles into a request with a one-cycle ready pulse.
  initial begin
    int cnt;
    cnt = 0;
    ram_ready = 1'b0;
    block_from_ram = '0;
    forever begin
      @(posedge clk); #1;
      ram_ready = 1'b0;
      if (ram_en_out && !rst) begin
        cnt++;
        if (cnt >= ram_lat) begin
          ram_ready = 1'b1;
          block_from_ram = fill_block;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // RAM request monitor.
  initial begin
    logic en_prev;
    logic [29:0] held;
    ram_exp_t e;
    en_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (ram_en_out && !en_prev) begin
        if (ram_q.size() == 0) chk("ram_unexpected_req", {34'h0, ram_addr_out}, 64'hFFFF_FFFF);
        else begin
          e = ram_q.pop_front();
          chk("ram_write", ram_write_out, e.wr);
          chk("ram_addr", ram_addr_out, e.addr);
          if (e.wr) chk("wb_word5", dc_data_wb[191:160], e.wb5);
        end
        held = ram_addr_out;
      end else if (ram_en_out) begin
        chk("ram_addr_stable", ram_addr_out, held);
      end
      en_prev = ram_en_out;
    end
  end

  // Read data monitor: pops whenever a read is presented without stall.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !mem_stall) begin
        if (ic_read_in) begin
          if (ic_q.size() == 0) chk("ic_unexpected", ic_data_out, 64'hDEAD);
          else begin e = ic_q.pop_front(); chk("ic_data", ic_data_out, e); end
        end
        if (dc_read_in) begin
          if (dc_q.size() == 0) chk("dc_unexpected", dc_data_out, 64'hDEAD);
          else begin e = dc_q.pop_front(); chk("dc_data", dc_data_out, e); end
        end
      end
    end
  end

  // Holds the request until one unstalled cycle; seq records status changes as {1,status} nibbles.
  task automatic access(input logic ic_r, input logic dc_r, input logic dc_w,
                        input logic [29:0] ia, input logic [29:0] da,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int cyc, output logic [31:0] seq);
    logic [2:0] last;
    @(posedge clk); #1;
    ic_read_in = ic_r; dc_read_in = dc_r; dc_write_in = dc_w;
    ic_addr = ia; dc_addr = da; dc_byte_w_en_in = be; data_from_reg = wd;
    cyc = 0; seq = 0; last = 3'h7;
    forever begin
      @(negedge clk);
      if (status != last) begin seq = {seq[27:0], 1'b1, status}; last = status; end
      if (!mem_stall) break;
      cyc++;
      if (cyc > 200) begin chk("access_timeout", cyc, 0); break; end
    end
    @(posedge clk); #1;
    ic_read_in = 0; dc_read_in = 0; dc_write_in = 0; dc_byte_w_en_in = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] seq;
    rst = 1; ic_read_in = 0; dc_read_in = 0; dc_write_in = 0; dc_byte_w_en_in = 0;
    ic_addr = 0; dc_addr = 0; data_from_reg = 0; fill_block = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_status", status, 0);
    chk("rst_counter", counter, 0);
    chk("rst_ram_en", ram_en_out, 0);
    chk("rst_ram_write", ram_write_out, 0);
    chk("rst_ram_addr", ram_addr_out, 0);
    chk("rst_wb_data", dc_data_wb[63:0], 0);
    chk("rst_stall", mem_stall, 0);

    // I-miss at 0x10
    fill_block = mk_block(32'h1234, 32'h1);
    ram_q.push_back('{1'b0, 30'h10, 32'h0});
    ic_q.push_back(32'h1234);
    access(1, 0, 0, 30'h10, 0, 0, 0, cyc, seq);
    chk("imiss_status_seq", seq, 32'h8BC8);

    // D read miss at 0x25, words = index*0x11
    fill_block = mk_block(32'h0, 32'h11);
    ram_q.push_back('{1'b0, 30'h20, 32'h0});
    dc_q.push_back(32'h55);
    access(0, 1, 0, 0, 30'h25, 0, 0, cyc, seq);
    chk("dmiss_status_seq", seq, 32'h8AC8);

    dc_q.push_back(32'h77);
    access(0, 1, 0, 0, 30'h27, 0, 0, cyc, seq);
    chk("dhit_0x27_latency", cyc, 0);

    // Store hit, byte 0 only
    access(0, 0, 1, 0, 30'h25, 4'b0001, 32'hAABBCCDD, cyc, seq);
    chk("store_hit_latency", cyc, 0);
    dc_q.push_back(32'h000000DD);
    access(0, 1, 0, 0, 30'h25, 0, 0, cyc, seq);

    // Conflict miss evicts the dirty line
    fill_block = mk_block(32'h100, 32'h1);
    ram_q.push_back('{1'b1, 30'h20, 32'hDD});
    ram_q.push_back('{1'b0, 30'h220, 32'h0});
    dc_q.push_back(32'h105);
    access(0, 1, 0, 0, 30'h225, 0, 0, cyc, seq);
    chk("wb_status_seq", seq, 32'h89AC8);

    // Store miss allocates, then writes
    fill_block = mk_block(32'h2000, 32'h1);
    ram_q.push_back('{1'b0, 30'h40, 32'h0});
    access(0, 0, 1, 0, 30'h40, 4'b1111, 32'hCAFEF00D, cyc, seq);
    chk("store_miss_seq", seq, 32'h8AC8);
    dc_q.push_back(32'hCAFEF00D);
    access(0, 1, 0, 0, 30'h40, 0, 0, cyc, seq);
    dc_q.push_back(32'h2001);
    access(0, 1, 0, 0, 30'h41, 0, 0, cyc, seq);

    // Simultaneous misses: D first, then I
    fill_block = mk_block(32'h3000, 32'h1);
    ram_q.push_back('{1'b0, 30'h88, 32'h0});
    ram_q.push_back('{1'b0, 30'h300, 32'h0});
    dc_q.push_back(32'h3003);
    ic_q.push_back(32'h3002);
    access(1, 1, 0, 30'h302, 30'h8B, 0, 0, cyc, seq);
    chk("dual_miss_seq", seq, 32'h8AC8BC8);

    // Reset in the middle of a DC_FILL
    ram_lat = 4;
    ram_q.push_back('{1'b0, 30'h500, 32'h0});
    @(posedge clk); #1;
    dc_read_in = 1; dc_addr = 30'h500;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ram_en_out) break;
      cyc++;
      if (cyc > 50) begin chk("rst_test_en_timeout", cyc, 0); break; end
    end
    chk("rst_test_in_fill", status, 2);
    @(posedge clk); #1;
    rst = 1; dc_read_in = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_status", status, 0);
    chk("midrst_ram_en", ram_en_out, 0);
    chk("midrst_counter", counter, 0);
    @(posedge clk); #1;
    ic_read_in = 1; ic_addr = 30'h10; dc_read_in = 1; dc_addr = 30'h225;
    @(negedge clk);
    chk("midrst_all_miss_stall", mem_stall, 1);
    chk("midrst_ic_data_zero", ic_data_out, 0);
    chk("midrst_dc_data_zero", dc_data_out, 0);
    #1 ic_read_in = 0; dc_read_in = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_status_idle", status, 0);
    chk("final_ram_en", ram_en_out, 0);
    chk("ram_q_empty", ram_q.size(), 0);
    chk("ic_q_empty", ic_q.size(), 0);
    chk("dc_q_empty", dc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_manager.md
# cache_manager

Two-level-memory front end between the pipeline and the DDR block controller. Holds a direct-mapped instruction cache and a direct-mapped write-back, write-allocate data cache, each with 8-word (256-bit) lines. Serves hits combinationally, and on a miss stalls the pipeline while it runs block write-back and fill transactions on a single shared RAM port.

## Interface
- `LINES`, 64, lines per cache (power of two); index = `log2(LINES)` bits, offset = 3 bits, tag = remaining bits of the 30-bit word address.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `ic_read_in` input 1: instruction fetch request.
- `dc_read_in` input 1: data load request.
- `dc_write_in` input 1: data store request.
- `dc_byte_w_en_in` input 4: store byte enables; bit i writes word bits [8i+7:8i].
- `ic_addr` input 30: instruction word address.
- `dc_addr` input 30: data word address.
- `data_from_reg` input 32: store data.
- `ram_ready` input 1: one-cycle completion pulse from the RAM controller.
- `block_from_ram` input 256: fill data, valid while `ram_ready`=1.
- `mem_stall` output 1: combinational pipeline stall.
- `dc_data_out` output 32: load data (combinational).
- `ic_data_out` output 32: fetch data (combinational).
- `status` output 3: FSM state code.
- `counter` output 3: cycles in current state, saturating at 7.
- `ram_en_out` output 1: RAM request.
- `ram_write_out` output 1: 1 = block write, 0 = block read.
- `ram_addr_out` output 30: block-aligned word address (bits [2:0] = 0).
- `dc_data_wb` output 256: victim block for write-back.

## Operation
- Block word w occupies bits [32w+31:32w] of `block_from_ram` and `dc_data_wb`.
- Hit: the line is valid and the stored tag equals the address tag.
- `ic_data_out` carries the array word on an I-hit; otherwise it is 0.
- `dc_data_out` carries the array word on a D-read hit; otherwise it is 0.
- Store hit while status is IDLE and `mem_stall`=0: the enabled bytes are written at the clock edge and the line's dirty bit is set.
- `mem_stall` = (status≠IDLE) | (dc_read_in|dc_write_in) & D-miss | ic_read_in & I-miss.
- FSM states:
  - 0 IDLE
  - 1 DC_WB: write back the dirty victim
  - 2 DC_FILL
  - 3 IC_FILL
  - 4 DONE: one settle cycle, then IDLE
- IDLE transitions:
  - D-miss with dirty victim → DC_WB.
  - D-miss with clean or invalid victim → DC_FILL.
  - Otherwise, I-miss → IC_FILL.
  - D-miss always has priority over I-miss.
- DC_WB: `ram_write_out`=1, `ram_addr_out`={victim tag, index, 3'b0}, `dc_data_wb`=victim line. On `ram_ready` → DC_FILL.
- DC_FILL / IC_FILL: `ram_write_out`=0, `ram_addr_out`={addr[29:3], 3'b0}. On `ram_ready`, the line is loaded from `block_from_ram`, valid=1, dirty=0 (D only), tag updated → DONE.
- After DONE the access re-evaluates in IDLE:
  - A pending store miss now hits and writes.
  - A still-pending I-miss starts IC_FILL.
- No coherence between the caches: stores do not update or invalidate the I-cache.
- Reset:
  - Clears all valid and dirty bits; status=0, counter=0.
  - `ram_en_out`=0, `ram_write_out`=0, `ram_addr_out`=0, `dc_data_wb`=0.
  - Data arrays are not cleared.
  - Reset mid-transaction abandons it; `ram_en_out` is 0 the cycle after reset.

## Timing
- Hits have zero latency (combinational). `mem_stall` rises in the same cycle as a miss.
- `ram_en_out`, `ram_write_out`, `ram_addr_out`, `dc_data_wb` are registered.
  - `ram_en_out` rises the cycle after a request state is entered.
  - It stays high, with address, write flag and data stable, until `ram_ready` is sampled high.
  - It is low in the following cycle, so there is at least one low cycle between consecutive transactions.
- `ram_ready` is ignored while `ram_en_out`=0.
- Clean miss, RAM ready after R cycles of request: stall lasts 1 (enter) + R + 1 (DONE) cycles, then the hit cycle.
- `counter` resets to 0 on every state change.

## Test plan
- After reset, `ic_read_in`=1, `ic_addr`=0x10 → `mem_stall`=1; status goes 3 then 4 then 0; `ram_addr_out`=0x10, `ram_write_out`=0. With `block_from_ram` word 0 = 0x1234, `ic_data_out`=0x1234 and `mem_stall`=0 in IDLE.
- D read miss at 0x25 with RAM block words = index×0x11 → `dc_data_out`=0x55 after the fill; a read of 0x27 hits immediately with 0x77.
- Store hit at 0x25 with `dc_byte_w_en_in`=4'b0001 and data 0xAABBCCDD → a later read gives 0x000000DD; the line is marked dirty.
- Conflicting read of 0x25 + LINES×8 → DC_WB with `ram_addr_out`=0x20, `ram_write_out`=1, `dc_data_wb` word 5 = 0xDD; then DC_FILL at the new address.
- Simultaneous I-miss and D-miss → DC_FILL is serviced first, then IC_FILL; `ram_en_out` is low for ≥1 cycle between the two.
- Assert `rst` while in DC_FILL with `ram_en_out`=1 → the next cycle shows status=0 and `ram_en_out`=0, and all lines miss.
